// File: rtl/seq_alu.sv
// Handshaked execution unit: single-cycle ALU ops plus iterative multiply/divide
// (one bit per cycle) behind valid/ready on both the issue and result sides.
//
// state | meaning
// IDLE  | waiting for an op, in_ready=1
// BUSY  | iterating mul/div, one bit per cycle
// DONE  | result/flags held, out_valid=1
module seq_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      opcode,
    input  logic [XLEN-1:0] op_0,
    input  logic [XLEN-1:0] op_1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            negative,
    output logic            carry,
    output logic            overflow,
    output logic            illegal
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_REMU  = 4'd13;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SHW-1:0]      r_cnt;
    logic [3:0]          r_op;
    logic [XLEN-1:0]     r_opnd;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_result;
    logic                r_zero;
    logic                r_negative;
    logic                r_carry;
    logic                r_overflow;
    logic                r_illegal;

    logic                w_iter;
    logic                w_accept;
    logic                w_last;
    logic [SHW-1:0]      w_shamt;
    logic [XLEN:0]       w_sum;
    logic [XLEN:0]       w_dif;
    logic [XLEN-1:0]     w_alu_res;
    logic                w_alu_c;
    logic                w_alu_v;
    logic                w_alu_ill;
    logic                w_is_div;
    logic [XLEN:0]       w_madd;
    logic [XLEN:0]       w_shift;
    logic                w_ge;
    logic [XLEN-1:0]     w_sub;
    logic [2*XLEN-1:0]   w_acc_nxt;
    logic [XLEN-1:0]     w_iter_res;

    assign w_iter   = (opcode >= OP_MUL) && (opcode <= OP_REMU);
    assign w_accept = in_valid && in_ready && !flush;
    assign w_last   = (r_state == S_BUSY) && (r_cnt == SHW'(XLEN - 1));

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid) w_state_nxt = w_iter ? S_BUSY : S_DONE;
                S_BUSY:  if (w_last) w_state_nxt = S_DONE;
                S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    // ---------------- single-cycle ALU ----------------
    assign w_shamt = op_1[SHW-1:0];
    assign w_sum   = {1'b0, op_0} + {1'b0, op_1};
    assign w_dif   = {1'b0, op_0} - {1'b0, op_1};

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_alu_ill = 1'b0;
        case (opcode)
            OP_ADD: begin
                w_alu_res = w_sum[XLEN-1:0];
                w_alu_c   = w_sum[XLEN];
                w_alu_v   = (op_0[XLEN-1] == op_1[XLEN-1]) && (w_sum[XLEN-1] != op_0[XLEN-1]);
            end
            OP_SUB: begin
                w_alu_res = w_dif[XLEN-1:0];
                w_alu_c   = w_dif[XLEN];
                w_alu_v   = (op_0[XLEN-1] != op_1[XLEN-1]) && (w_dif[XLEN-1] != op_0[XLEN-1]);
            end
            OP_AND:  w_alu_res = op_0 & op_1;
            OP_OR:   w_alu_res = op_0 | op_1;
            OP_XOR:  w_alu_res = op_0 ^ op_1;
            OP_SLL:  w_alu_res = op_0 << w_shamt;
            OP_SRL:  w_alu_res = op_0 >> w_shamt;
            OP_SRA:  w_alu_res = $unsigned($signed(op_0) >>> w_shamt);
            OP_SLT:  w_alu_res = XLEN'($signed(op_0) < $signed(op_1));
            OP_SLTU: w_alu_res = XLEN'(op_0 < op_1);
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: w_alu_res = '0;
            default: w_alu_ill = 1'b1;
        endcase
    end

    // ---------------- iterative datapath ----------------
    // r_acc holds {high, multiplier} for mul and {remainder, dividend/quotient} for div.
    assign w_is_div = (r_op == OP_DIVU) || (r_op == OP_REMU);
    assign w_madd   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_shift  = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge     = (w_shift >= {1'b0, r_opnd});
    assign w_sub    = w_shift[XLEN-1:0] - r_opnd;

    always_comb begin
        if (!w_is_div)
            w_acc_nxt = {w_madd, r_acc[XLEN-1:1]};
        else if (w_ge)
            w_acc_nxt = {w_sub, r_acc[XLEN-2:0], 1'b1};
        else
            w_acc_nxt = {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        w_iter_res = ((r_op == OP_MULHU) || (r_op == OP_REMU)) ?
                     w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_op       <= '0;
            r_opnd     <= '0;
            r_acc      <= '0;
            r_result   <= '0;
            r_zero     <= 1'b1;
            r_negative <= 1'b0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_op  <= opcode;
            if (w_iter) begin
                r_opnd <= op_1;
                r_acc  <= {{XLEN{1'b0}}, op_0};
            end else begin
                r_result   <= w_alu_res;
                r_zero     <= (w_alu_res == '0);
                r_negative <= w_alu_res[XLEN-1];
                r_carry    <= w_alu_c;
                r_overflow <= w_alu_v;
                r_illegal  <= w_alu_ill;
            end
        end else if ((r_state == S_BUSY) && !flush) begin
            r_cnt <= r_cnt + SHW'(1);
            r_acc <= w_acc_nxt;
            if (w_last) begin
                r_result   <= w_iter_res;
                r_zero     <= (w_iter_res == '0);
                r_negative <= w_iter_res[XLEN-1];
                r_carry    <= 1'b0;
                r_overflow <= 1'b0;
                r_illegal  <= 1'b0;
            end
        end
    end

    assign result   = r_result;
    assign zero     = r_zero;
    assign negative = r_negative;
    assign carry    = r_carry;
    assign overflow = r_overflow;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at XLEN=32 and XLEN=8: results, flags, latency,
// hold-while-stalled, flush and mid-operation reset.
module tb_seq_alu;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [3:0]  opcode;
    logic [31:0] op_0, op_1, result;
    logic        zero, negative, carry, overflow, illegal;

    logic        in_valid_8, in_ready_8, out_valid_8, out_ready_8;
    logic [3:0]  opcode_8;
    logic [7:0]  op_0_8, op_1_8, result_8;
    logic        zero_8, negative_8, carry_8, overflow_8, illegal_8;

    int checks = 0;
    int errors = 0;
    int lat;

    seq_alu #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
        .op_0(op_0), .op_1(op_1),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .negative(negative), .carry(carry),
        .overflow(overflow), .illegal(illegal)
    );

    seq_alu #(.XLEN(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid_8), .in_ready(in_ready_8), .opcode(opcode_8),
        .op_0(op_0_8), .op_1(op_1_8),
        .out_valid(out_valid_8), .out_ready(out_ready_8), .result(result_8),
        .zero(zero_8), .negative(negative_8), .carry(carry_8),
        .overflow(overflow_8), .illegal(illegal_8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags packed as {zero, negative, carry, overflow, illegal}
    task automatic chk32(input string tag, input logic [31:0] r, input logic [4:0] f);
        chk(tag, result, r);
        chk({tag, "_flags"}, {zero, negative, carry, overflow, illegal}, f);
    endtask

    task automatic chk8(input string tag, input logic [7:0] r, input logic [4:0] f);
        chk(tag, result_8, r);
        chk({tag, "_flags"}, {zero_8, negative_8, carry_8, overflow_8, illegal_8}, f);
    endtask

    // Issue one op, scramble inputs after acceptance, return cycles until out_valid.
    task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int l);
        opcode = op; op_0 = a; op_1 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; opcode = 4'd4; op_0 = 32'hDEADBEEF; op_1 = 32'h0BADF00D;
        l = 1;
        while (!out_valid && l < 100) begin @(posedge clk); #1; l++; end
    endtask

    task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int l);
        opcode_8 = op; op_0_8 = a; op_1_8 = b; in_valid_8 = 1'b1;
        @(posedge clk); #1;
        in_valid_8 = 1'b0; opcode_8 = 4'd4; op_0_8 = 8'hA5; op_1_8 = 8'h3C;
        l = 1;
        while (!out_valid_8 && l < 100) begin @(posedge clk); #1; l++; end
    endtask

    task automatic take32();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("xfer_ovalid", out_valid, 1'b0);
        chk("xfer_iready", in_ready, 1'b1);
    endtask

    task automatic take8();
        out_ready_8 = 1'b1;
        @(posedge clk); #1;
        out_ready_8 = 1'b0;
        chk("xfer8_ovalid", out_valid_8, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; opcode = '0; op_0 = '0; op_1 = '0;
        in_valid_8 = 1'b0; out_ready_8 = 1'b0; opcode_8 = '0; op_0_8 = '0; op_1_8 = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_iready", in_ready, 1'b1);
        chk("rst_ovalid", out_valid, 1'b0);
        chk32("rst", 32'h0, 5'b10000);
        chk("rst8_iready", in_ready_8, 1'b1);
        chk8("rst8", 8'h0, 5'b10000);

        issue32(4'd0, 32'h7FFFFFFF, 32'h1, lat);
        chk("add_lat", lat, 1);
        chk32("add", 32'h80000000, 5'b01010);
        take32();

        issue32(4'd1, 32'd3, 32'd5, lat);
        chk("sub_lat", lat, 1);
        chk32("sub", 32'hFFFFFFFE, 5'b01100);
        take32();

        issue32(4'd7, 32'h80000000, 32'h24, lat);
        chk32("sra", 32'hF8000000, 5'b01000);
        take32();

        issue32(4'd9, 32'h1, 32'hFFFFFFFF, lat);
        chk32("sltu", 32'h1, 5'b00000);
        take32();

        issue32(4'd8, 32'h1, 32'hFFFFFFFF, lat);
        chk32("slt", 32'h0, 5'b10000);
        take32();

        issue32(4'd4, 32'hA5A5A5A5, 32'hFFFF0000, lat);
        chk32("xor", 32'h5A5AA5A5, 5'b00000);
        take32();

        issue32(4'd5, 32'h1, 32'hFF, lat);
        chk32("sll", 32'h80000000, 5'b01000);
        take32();

        issue32(4'd6, 32'h80000000, 32'h1F, lat);
        chk32("srl", 32'h1, 5'b00000);
        take32();

        issue32(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        chk("mul_lat", lat, 33);
        chk32("mul", 32'h00000001, 5'b00000);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("hold_ovalid", out_valid, 1'b1);
            chk("hold_result", result, 32'h00000001);
        end
        take32();

        issue32(4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
        chk("mulhu_lat", lat, 33);
        chk32("mulhu", 32'hFFFFFFFE, 5'b01000);
        take32();

        issue32(4'd12, 32'd100, 32'd7, lat);
        chk("divu_lat", lat, 33);
        chk32("divu", 32'd14, 5'b00000);
        take32();

        issue32(4'd13, 32'd100, 32'd7, lat);
        chk32("remu", 32'd2, 5'b00000);
        take32();

        issue32(4'd12, 32'd5, 32'd0, lat);
        chk("divz_lat", lat, 33);
        chk32("divu_z", 32'hFFFFFFFF, 5'b01000);
        take32();

        issue32(4'd13, 32'h1234, 32'd0, lat);
        chk("remz_lat", lat, 33);
        chk32("remu_z", 32'h1234, 5'b00000);
        take32();

        issue32(4'd15, 32'h11, 32'h22, lat);
        chk("ill_lat", lat, 1);
        chk32("ill15", 32'h0, 5'b10001);
        take32();

        issue32(4'd14, 32'h11, 32'h22, lat);
        chk32("ill14", 32'h0, 5'b10001);
        take32();

        // flush during the 10th BUSY cycle
        opcode = 4'd10; op_0 = 32'hFFFFFFFF; op_1 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_iready", in_ready, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_ovalid", out_valid, 1'b0);
        chk("flush_iready", in_ready, 1'b1);
        repeat (40) @(posedge clk);
        #1 chk("flush_quiet", out_valid, 1'b0);

        // flush beats acceptance
        opcode = 4'd0; op_0 = 32'd1; op_1 = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_acc_ovalid", out_valid, 1'b0);
        chk("flush_acc_iready", in_ready, 1'b1);

        issue32(4'd12, 32'd200, 32'd9, lat);
        chk("post_flush_lat", lat, 33);
        chk32("post_flush_divu", 32'd22, 5'b00000);

        // flush beats transfer while holding a result
        out_ready = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; flush = 1'b0;
        chk("flush_done_ovalid", out_valid, 1'b0);
        chk("flush_done_iready", in_ready, 1'b1);

        issue32(4'd1, 32'd9, 32'd2, lat);
        chk32("sub2", 32'd7, 5'b00000);

        // reset mid-BUSY (held result 7 must be cleared)
        take32();
        opcode = 4'd12; op_0 = 32'd1000; op_1 = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rstb_iready", in_ready, 1'b1);
        chk("rstb_ovalid", out_valid, 1'b0);
        chk32("rstb", 32'h0, 5'b10000);
        repeat (40) @(posedge clk);
        #1 chk("rstb_quiet", out_valid, 1'b0);

        issue8(4'd12, 8'd100, 8'd7, lat);
        chk("divu8_lat", lat, 9);
        chk8("divu8", 8'd14, 5'b00000);
        take8();

        issue8(4'd13, 8'd100, 8'd7, lat);
        chk("remu8_lat", lat, 9);
        chk8("remu8", 8'd2, 5'b00000);
        take8();

        issue8(4'd10, 8'hFF, 8'hFF, lat);
        chk("mul8_lat", lat, 9);
        chk8("mul8", 8'h01, 5'b00000);
        take8();

        issue8(4'd11, 8'hFF, 8'hFF, lat);
        chk8("mulhu8", 8'hFE, 5'b01000);
        take8();

        issue8(4'd12, 8'h37, 8'h00, lat);
        chk8("divu8_z", 8'hFF, 5'b01000);
        take8();

        issue8(4'd0, 8'h7F, 8'h01, lat);
        chk("add8_lat", lat, 1);
        chk8("add8", 8'h80, 5'b01010);
        take8();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked execution unit that supersedes the purely combinational ALU in the RISC-V datapath. Single-cycle ops (add/sub/logic/shift/compare) return after one registered cycle. Multiply-high/low and unsigned divide/remainder run on an iterative datapath, one bit per cycle. The block sits between the decode/register-read stage and writeback, with valid/ready on both sides so the pipeline can stall on long operations.

## Interface
- XLEN, 32, operand/result width; power of two, ≥ 8
- SHW, $clog2(XLEN), shift-amount width, derived (not overridden)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  abort any in-flight op, drop held result
- in_valid  in  1  operands/opcode valid
- in_ready  out  1  unit can accept an op
- opcode  in  4  operation select (below)
- op_0  in  XLEN  first operand
- op_1  in  XLEN  second operand (shift amount = op_1[SHW-1:0])
- out_valid  out  1  result/flags valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  operation result
- zero  out  1  result == 0
- negative  out  1  result[XLEN-1]
- carry  out  1  ADD carry-out; SUB borrow (op_0 <u op_1); else 0
- overflow  out  1  signed overflow for ADD/SUB; else 0
- illegal  out  1  opcode 14/15 was issued

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA (arithmetic), 8 SLT (signed, result 0/1), 9 SLTU, 10 MUL (low XLEN of unsigned product), 11 MULHU (high XLEN), 12 DIVU, 13 REMU, 14–15 illegal.
- Illegal: result 0, illegal=1, single-cycle latency, all other flags computed from result 0 (zero=1).
- Divide by zero: DIVU → all ones, REMU → op_0; takes the full iterative latency; no separate flag.
- MUL/MULHU: shift-add, 2·XLEN-bit accumulator, one multiplier bit per cycle, LSB first.
- DIVU/REMU: restoring division, one quotient bit per cycle, MSB first; XLEN-bit remainder register plus 1 guard bit.
- Operands are captured at acceptance; later changes on op_0/op_1/opcode do not affect an in-flight op.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, a single-cycle op goes to DONE; an iterative op loads the operands, clears the counter, and goes to BUSY.
  - BUSY: in_ready=0. Counter increments each cycle; after iteration XLEN-1 the FSM goes to DONE.
  - DONE: out_valid=1. On out_ready, the FSM goes to IDLE.
- in_ready is high only in IDLE; the unit holds at most one op (no back-to-back overlap).
- Flags are registered with result and are valid only while out_valid=1.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, counter 0, out_valid 0, result 0, zero 1, negative/carry/overflow/illegal 0. This applies from any state, including mid-BUSY.
- Acceptance at edge T (in_valid & in_ready).
- Single-cycle ops: out_valid=1 after edge T+1.
- Iterative ops: BUSY during cycles T+1..T+XLEN; out_valid=1 after edge T+XLEN+1.
- Result transfer at the edge where out_valid & out_ready. in_ready=1 from the next cycle, so the next op is accepted no earlier than transfer edge +1.
- result and flags stay stable while out_valid=1 and out_ready=0, for any number of cycles.
- flush at an edge: the FSM goes to IDLE and out_valid falls. flush has priority over acceptance and transfer in the same cycle. rst_n has priority over flush.
- in_valid while BUSY/DONE is ignored; the source must hold it until in_ready.

## Test plan
- Reset then idle: rst_n low 2 cycles, then high → in_ready=1, out_valid=0, result=0, zero=1.
- ADD 0x7FFFFFFF+1 (XLEN=32) → out_valid after 1 cycle; result 0x80000000, negative=1, overflow=1, carry=0. SUB 3−5 → 0xFFFFFFFE, carry=1.
- SRA 0x80000000 by op_1=0x24 (amount 4) → 0xF8000000. SLTU 1 vs 0xFFFFFFFF → 1. SLT same operands → 0.
- MUL/MULHU 0xFFFFFFFF×0xFFFFFFFF → low 0x00000001, high 0xFFFFFFFE; out_valid exactly 33 cycles after acceptance. Hold out_ready=0 for 5 cycles → result stable.
- DIVU 100/7 → 14, REMU → 2. DIVU x/0 → 0xFFFFFFFF, REMU 0x1234/0 → 0x1234. Repeat with XLEN=8: latency 9 cycles.
- flush at BUSY cycle 10, and separately rst_n low mid-BUSY → IDLE next cycle, no out_valid. Opcode 15 → illegal=1, result 0.
